// File: rtl/operand_issue.sv
// Operand-read / issue stage between decode and execute: regfile read, writeback bypass,
// busy scoreboard for RAW/WAW hazards and a one-entry valid/ready register feeding execute.
module operand_issue #(
    parameter int XLEN   = 32,
    parameter int REG_N  = 32,
    parameter int CTRL_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              dec_valid_i,
    output logic              dec_ready_o,
    input  logic              dec_rs1_en_i,
    input  logic [4:0]        dec_rs1_addr_i,
    input  logic              dec_rs2_en_i,
    input  logic [4:0]        dec_rs2_addr_i,
    input  logic              dec_rd_en_i,
    input  logic [4:0]        dec_rd_addr_i,
    input  logic [CTRL_W-1:0] dec_ctrl_i,
    output logic [4:0]        rs1_rd_addr_o,
    output logic [4:0]        rs2_rd_addr_o,
    input  logic [XLEN-1:0]   rs1_rd_data_i,
    input  logic [XLEN-1:0]   rs2_rd_data_i,
    input  logic              wb_en_i,
    input  logic [4:0]        wb_addr_i,
    input  logic [XLEN-1:0]   wb_data_i,
    input  logic              flush_i,
    output logic              ex_valid_o,
    input  logic              ex_ready_i,
    output logic [XLEN-1:0]   ex_rs1_data_o,
    output logic [XLEN-1:0]   ex_rs2_data_o,
    output logic              ex_rd_en_o,
    output logic [4:0]        ex_rd_addr_o,
    output logic [CTRL_W-1:0] ex_ctrl_o
);
    localparam int AW = $clog2(REG_N);

    typedef struct packed {
        logic [XLEN-1:0]   rs1_data;
        logic [XLEN-1:0]   rs2_data;
        logic              rd_en;
        logic [4:0]        rd_addr;
        logic [CTRL_W-1:0] ctrl;
    } ex_entry_t;

    logic [REG_N-1:0] busy_q, busy_d;
    logic [AW-1:0]    rs1_idx, rs2_idx, rd_idx, wb_idx, ex_rd_idx;
    logic             rs1_live, rs2_live, rd_live;
    logic             clr_rs1, clr_rs2, clr_rd, hazard, fire;
    logic [1:0]       vld_pipe;
    ex_entry_t        ex_q, ex_d;

    // Only the low log2(REG_N) address bits select a register.
    assign rs1_idx   = dec_rs1_addr_i[AW-1:0];
    assign rs2_idx   = dec_rs2_addr_i[AW-1:0];
    assign rd_idx    = dec_rd_addr_i[AW-1:0];
    assign wb_idx    = wb_addr_i[AW-1:0];
    assign ex_rd_idx = ex_q.rd_addr[AW-1:0];

    assign rs1_rd_addr_o = dec_rs1_addr_i;
    assign rs2_rd_addr_o = dec_rs2_addr_i;

    assign rs1_live = dec_rs1_en_i && (rs1_idx != '0);
    assign rs2_live = dec_rs2_en_i && (rs2_idx != '0);
    assign rd_live  = dec_rd_en_i  && (rd_idx  != '0);

    // A writeback landing this cycle already resolves the pending write it targets.
    assign clr_rs1 = wb_en_i && (wb_idx == rs1_idx);
    assign clr_rs2 = wb_en_i && (wb_idx == rs2_idx);
    assign clr_rd  = wb_en_i && (wb_idx == rd_idx);

    assign hazard = (rs1_live && busy_q[rs1_idx] && !clr_rs1) ||
                    (rs2_live && busy_q[rs2_idx] && !clr_rs2) ||
                    (rd_live  && busy_q[rd_idx]  && !clr_rd);

    assign dec_ready_o = !flush_i && !hazard && (!vld_pipe[1] || ex_ready_i);
    assign fire        = dec_valid_i && dec_ready_o;
    assign vld_pipe[0] = fire;

    always_comb begin
        ex_d          = '0;
        ex_d.rs1_data = !rs1_live ? '0 : clr_rs1 ? wb_data_i : rs1_rd_data_i;
        ex_d.rs2_data = !rs2_live ? '0 : clr_rs2 ? wb_data_i : rs2_rd_data_i;
        ex_d.rd_en    = dec_rd_en_i;
        ex_d.rd_addr  = dec_rd_addr_i;
        ex_d.ctrl     = dec_ctrl_i;
    end

    // Order matters: set after clears so a same-cycle set on one register wins.
    always_comb begin
        busy_d = busy_q;
        if (wb_en_i)
            busy_d[wb_idx] = 1'b0;
        if (flush_i && vld_pipe[1] && ex_q.rd_en)
            busy_d[ex_rd_idx] = 1'b0;
        if (fire && rd_live)
            busy_d[rd_idx] = 1'b1;
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            busy_q      <= '0;
            vld_pipe[1] <= 1'b0;
            ex_q        <= '0;
        end else begin
            busy_q <= busy_d;
            if (flush_i) begin
                vld_pipe[1] <= 1'b0;
            end else if (vld_pipe[0]) begin
                vld_pipe[1] <= 1'b1;
                ex_q        <= ex_d;
            end else if (ex_ready_i) begin
                vld_pipe[1] <= 1'b0;
            end
        end
    end

    assign ex_valid_o    = vld_pipe[1];
    assign ex_rs1_data_o = ex_q.rs1_data;
    assign ex_rs2_data_o = ex_q.rs2_data;
    assign ex_rd_en_o    = ex_q.rd_en;
    assign ex_rd_addr_o  = ex_q.rd_addr;
    assign ex_ctrl_o     = ex_q.ctrl;

endmodule
